inst_fetch: RTL
===============

// Module: inst_fetch
// PURPOSE
//  Instruction fetch stage feeding the decoder: owns the PC, issues word reads to instruction memory,
//  buffers returned words with their PC in a small in-order queue, and presents them on a valid/ready
//  interface. Sits directly upstream of the decoder; execute drives redirects (taken branch, JAL, JALR).
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC of first fetch after reset; bits [1:0] must be 0
//  FIFO_DEPTH  4              instruction queue entries (power of 2, >=2); also caps outstanding reads
// PORTS
//  clk             in   1   clock; all state updates on posedge
//  rst_n           in   1   asynchronous, active-low reset
//  imem_req        out  1   read request valid (combinational from state)
//  imem_addr       out  32  word-aligned read address (= fetch PC)
//  imem_gnt        in   1   request accepted this cycle (req&&gnt = handshake)
//  imem_rvalid     in   1   read data valid; responses in request order, >=1 cycle after grant
//  imem_rdata      in   32  read data
//  redirect_valid  in   1   flush and restart fetch at redirect_pc
//  redirect_pc     in   32  new PC; bits [1:0] ignored (treated as 0)
//  halt            in   1   stop issuing new requests while high
//  inst_valid      out  1   inst/inst_pc hold a valid instruction
//  inst_ready      in   1   decoder accepts (inst_valid&&inst_ready = pop)
//  inst            out  32  instruction word; 32'h0000_0013 (NOP) whenever inst_valid=0
//  inst_pc         out  32  PC of inst; 0 whenever inst_valid=0
// BEHAVIOUR
//  Reset (async): pc=RESET_PC, queue empty, outstanding=0, drop_cnt=0; imem_req=0, inst_valid=0,
//   inst=NOP, inst_pc=0. First request may assert in the first cycle after rst_n deasserts.
//  Credit = free_entries - (outstanding - drop_cnt). imem_req = !halt && !redirect_valid && credit>0.
//  Grant: pc <= pc+4 (wraps mod 2^32), outstanding++. Response: outstanding--.
//  Response with drop_cnt>0: discarded, drop_cnt--. Otherwise {pc_of_req, rdata} pushed to queue.
//   PC of each in-flight request tracked in order (side queue of FIFO_DEPTH entries).
//  Queue never overflows: credit guarantees a slot for every non-dropped response.
//  Redirect (highest priority): pc <= {redirect_pc[31:2],2'b00}; queue flushed; no request that cycle;
//   drop_cnt <= outstanding - imem_rvalid (response in redirect cycle also discarded); any pop that
//   cycle is still honoured by the decoder, but inst_valid=0 from the next cycle until new data.
//  Simultaneous grant+response, or push+pop on a full queue: both take effect; counters stay exact.
//  halt: in-flight reads complete and are queued; queue keeps draining; deasserting resumes at pc.
//  Latency (no bypass): grant at T, rvalid at T+k -> inst_valid at T+k+1.
// CONFIGURATION
//  FETCH_BYPASS_EN defined: queue empty && response valid && not dropped && !redirect_valid ->
//   inst/inst_pc/inst_valid driven combinationally from imem_rdata same cycle; if inst_ready the
//   word is consumed without being pushed, else pushed normally. Latency T+k.
//  Not defined: every response goes through the queue; outputs purely registered/queue-head.
// STRUCTURE
//  rv32i_pkg: INST_NOP=32'h0000_0013, typedef fetch_entry_t {logic [31:0] pc; logic [31:0] inst;}.
//  Sub-module fetch_fifo (parameterised depth, push/pop/flush, full/empty/count), instantiated for
//  the instruction queue and the in-flight PC queue. Top holds pc, outstanding, drop_cnt, req logic.
// TESTING
//  Reset, gnt=1, 1-cycle memory, ready=1 -> imem_addr 0,4,8,...; inst_pc sequence 0,4,8 one per cycle.
//  ready=0 held -> exactly FIFO_DEPTH requests granted, then imem_req=0; release -> 4 insts in order.
//  3 reads outstanding, redirect_pc=32'h100 -> the 3 responses dropped; next inst_pc=32'h100.
//  redirect_pc=32'h203 -> imem_addr=32'h200, inst_pc=32'h200.
//  halt=1 with 2 outstanding -> both delivered, no new req; halt=0 -> fetch resumes at next PC.
//  pc=32'hFFFF_FFFC -> next imem_addr 32'h0; compare both FETCH_BYPASS_EN builds for latency T+k vs T+k+1.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I fetch types and constants.
// Imported by the fetch stage and its queues.
package rv32i_pkg;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order queue with push/pop/flush and occupancy count.
// Push while full is accepted only together with a pop.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    push,
  input  logic [W-1:0]            wdata,
  input  logic                    pop,
  output logic [W-1:0]            rdata,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DC = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == DC);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      if (do_push && !do_pop)
        count <= count + CW'(1);
      else if (do_pop && !do_push)
        count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, imem requests, in-order queue.
// Define FETCH_BYPASS_EN to forward a response straight to decode.
module inst_fetch
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = $bits(fetch_entry_t);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] q_count;
  logic [CW-1:0] live;
  logic [CW-1:0] free;
  logic          q_full;
  logic          q_empty;
  logic          pcq_full;
  logic          pcq_empty;
  logic [31:0]   rsp_pc;
  fetch_entry_t  q_head;
  fetch_entry_t  rsp_entry;
  logic          grant;
  logic          rsp_keep;
  logic          byp;
  logic          q_push;
  logic          q_pop;

  // Slots already promised to live reads are not free for new requests.
  assign live      = outstanding - drop_cnt;
  assign free      = DEPTH_C - q_count;
  assign imem_req  = rst_n && !halt && !redirect_valid && !q_full &&
                     !pcq_full && (free > live);
  assign imem_addr = pc;
  assign grant     = imem_req && imem_gnt;

  assign rsp_keep  = imem_rvalid && !pcq_empty &&
                     (drop_cnt == '0) && !redirect_valid;
  assign rsp_entry = '{pc: rsp_pc, inst: imem_rdata};

`ifdef FETCH_BYPASS_EN
  assign byp = q_empty && rsp_keep;
`else
  assign byp = 1'b0;
`endif

  assign q_push     = rsp_keep && !(byp && inst_ready);
  assign q_pop      = !q_empty && inst_ready;
  assign inst_valid = !q_empty || byp;

  always_comb begin
    inst    = INST_NOP;
    inst_pc = '0;
    if (!q_empty) begin
      inst    = q_head.inst;
      inst_pc = q_head.pc;
    end else if (byp) begin
      inst    = imem_rdata;
      inst_pc = rsp_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc & 32'hFFFF_FFFC;
      drop_cnt <= outstanding - CW'(imem_rvalid);
    end else begin
      if (grant) pc <= pc + 32'd4;
      if (imem_rvalid && drop_cnt != '0)
        drop_cnt <= drop_cnt - CW'(1);
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EW)
  ) u_inst_q (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (q_push),
    .wdata (rsp_entry),
    .pop   (q_pop),
    .rdata (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  // PCs of in-flight reads; never flushed so dropped replies still retire.
  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (32)
  ) u_pc_q (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (1'b0),
    .push  (grant),
    .wdata (pc),
    .pop   (imem_rvalid),
    .rdata (rsp_pc),
    .full  (pcq_full),
    .empty (pcq_empty),
    .count (outstanding)
  );

endmodule
